// File: rtl/ldm_stm_sequencer.sv
// Block-transfer micro-op sequencer (LDM/STM).
// Walks a captured register list lowest-index first, emitting one
// register index and word address per accepted cycle, then pulses the
// final writeback base for one cycle before returning to idle.
module ldm_stm_sequencer #(
    parameter int NREGS  = 16,
    parameter int IDXW   = $clog2(NREGS),
    parameter int AW     = 32,
    parameter int WBYTES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartD,
    input  logic [NREGS-1:0] RegListD,
    input  logic [AW-1:0]    BaseD,
    input  logic             UpD,
    input  logic             PreD,
    input  logic             ReadyE,
    input  logic             FlushD,
    output logic             BusyD,
    output logic             UopValid,
    output logic [IDXW-1:0]  UopRd,
    output logic [AW-1:0]    UopAddr,
    output logic             UopFirst,
    output logic             UopLast,
    output logic             WBValid,
    output logic [AW-1:0]    WBBase
);
    localparam int            CW     = $clog2(NREGS + 1);
    localparam logic [AW-1:0] STRIDE = AW'(WBYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [NREGS-1:0] r_list;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    r_final;
    logic             r_busy;
    logic             r_valid;
    logic             r_first;
    logic             r_last;
    logic             r_wb_valid;
    logic [AW-1:0]    r_wb_base;

    logic [CW-1:0]    w_pop;
    logic [AW-1:0]    w_span;
    logic [AW-1:0]    w_start;
    logic [AW-1:0]    w_final;
    logic [IDXW-1:0]  w_rd;

    // Number of registers in the incoming list.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NREGS; i++)
            w_pop = w_pop + CW'(RegListD[i]);
    end

    // Lowest register always goes to the lowest address, so the start
    // address is the bottom of the block in every addressing mode.
    always_comb begin
        w_span  = AW'(w_pop) * STRIDE;
        w_start = UpD ? (BaseD + (PreD ? STRIDE : '0))
                      : (BaseD - w_span + (PreD ? '0 : STRIDE));
        w_final = UpD ? (BaseD + w_span) : (BaseD - w_span);
    end

    // Index of the lowest set bit in the remaining list.
    always_comb begin
        w_rd = '0;
        for (int i = NREGS - 1; i >= 0; i--)
            if (r_list[i]) w_rd = IDXW'(i);
    end

    // Sequencer FSM with registered handshake/writeback outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_list     <= '0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_final    <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_base  <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            if (FlushD) begin
                r_state <= IDLE;
                r_list  <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
                r_valid <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (StartD) begin
                        r_list  <= RegListD;
                        r_cnt   <= w_pop;
                        r_addr  <= w_start;
                        r_final <= w_final;
                        if (w_pop != '0) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_valid <= 1'b1;
                            r_first <= 1'b1;
                            r_last  <= (w_pop == CW'(1));
                        end else begin
                            // Empty list: straight to writeback.
                            r_state    <= DONE;
                            r_wb_valid <= 1'b1;
                            r_wb_base  <= w_final;
                        end
                    end
                    RUN: if (ReadyE) begin
                        r_list  <= r_list & (r_list - NREGS'(1));
                        r_addr  <= r_addr + STRIDE;
                        r_cnt   <= r_cnt - CW'(1);
                        r_first <= 1'b0;
                        r_last  <= (r_cnt == CW'(2));
                        if (r_cnt == CW'(1)) begin
                            r_state    <= DONE;
                            r_busy     <= 1'b0;
                            r_valid    <= 1'b0;
                            r_last     <= 1'b0;
                            r_wb_valid <= 1'b1;
                            r_wb_base  <= r_final;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign BusyD    = r_busy;
    assign UopValid = r_valid;
    assign UopRd    = w_rd;
    assign UopAddr  = r_addr;
    assign UopFirst = r_first;
    assign UopLast  = r_last;
    assign WBValid  = r_wb_valid;
    assign WBBase   = r_wb_base;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: IA/DB/IB/DA modes, backpressure,
// empty list, flush, async reset and address wrap.
module tb_ldm_stm_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        StartD;
    logic [15:0] RegListD;
    logic [31:0] BaseD;
    logic        UpD, PreD, ReadyE, FlushD;
    logic        BusyD, UopValid, UopFirst, UopLast, WBValid;
    logic [3:0]  UopRd;
    logic [31:0] UopAddr, WBBase;

    int n_chk = 0;
    int n_err = 0;

    ldm_stm_sequencer dut (
        .clk(clk), .reset(reset), .StartD(StartD), .RegListD(RegListD),
        .BaseD(BaseD), .UpD(UpD), .PreD(PreD), .ReadyE(ReadyE),
        .FlushD(FlushD), .BusyD(BusyD), .UopValid(UopValid), .UopRd(UopRd),
        .UopAddr(UopAddr), .UopFirst(UopFirst), .UopLast(UopLast),
        .WBValid(WBValid), .WBBase(WBBase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one sequence and walk it. Expected register order is ascending
    // bit index; addresses climb by 4 from the hand-computed start address.
    task automatic run_seq(input logic [15:0] list, input logic [31:0] base,
                           input logic up, input logic pre,
                           input logic [31:0] exp_start, input logic [31:0] exp_final,
                           input int stall_at, input int stall_cyc);
        int          k;
        int          n;
        logic [31:0] a;
        k = 0;
        n = $countones(list);
        a = exp_start;
        ReadyE = 1'b1;
        StartD = 1'b1; RegListD = list; BaseD = base; UpD = up; PreD = pre;
        tick();
        StartD = 1'b0; RegListD = '0; BaseD = '0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                if (k == stall_at) begin
                    ReadyE = 1'b0;
                    for (int s = 0; s < stall_cyc; s++) begin
                        // A start during RUN must be ignored.
                        StartD = 1'b1; RegListD = 16'h0100; BaseD = 32'hDEAD0000;
                        chk("stall_valid", 32'(UopValid), 32'd1);
                        chk("stall_rd",    32'(UopRd),    i);
                        chk("stall_addr",  UopAddr,       a);
                        tick();
                    end
                    StartD = 1'b0; RegListD = '0; BaseD = '0;
                    ReadyE = 1'b1;
                end
                chk("uop_valid", 32'(UopValid), 32'd1);
                chk("busy",      32'(BusyD),    32'd1);
                chk("uop_rd",    32'(UopRd),    i);
                chk("uop_addr",  UopAddr,       a);
                chk("uop_first", 32'(UopFirst), 32'(k == 0));
                chk("uop_last",  32'(UopLast),  32'(k == n - 1));
                chk("no_wb",     32'(WBValid),  32'd0);
                tick();
                k++;
                a = a + 32'd4;
            end
        end
        chk("wb_valid",   32'(WBValid),  32'd1);
        chk("wb_base",    WBBase,        exp_final);
        chk("done_valid", 32'(UopValid), 32'd0);
        chk("done_busy",  32'(BusyD),    32'd0);
        tick();
        chk("wb_pulse",   32'(WBValid),  32'd0);
        chk("idle_busy",  32'(BusyD),    32'd0);
    endtask

    initial begin
        reset = 1'b1; StartD = 1'b0; RegListD = '0; BaseD = '0;
        UpD = 1'b0; PreD = 1'b0; ReadyE = 1'b0; FlushD = 1'b0;
        tick();
        chk("rst_busy",  32'(BusyD),    32'd0);
        chk("rst_valid", 32'(UopValid), 32'd0);
        chk("rst_rd",    32'(UopRd),    32'd0);
        chk("rst_addr",  UopAddr,       32'd0);
        chk("rst_wb",    32'(WBValid),  32'd0);
        chk("rst_wbb",   WBBase,        32'd0);
        reset = 1'b0;
        tick();

        // IA: r0@1000 r2@1004 r15@1008, final 100C
        run_seq(16'h8005, 32'h1000, 1'b1, 1'b0, 32'h1000, 32'h100C, -1, 0);
        // DB: r4..r7 from 1FF0, final 1FF0
        run_seq(16'h00F0, 32'h2000, 1'b0, 1'b1, 32'h1FF0, 32'h1FF0, -1, 0);
        // Backpressure on the 2nd uop for 3 cycles
        run_seq(16'h000F, 32'h0500, 1'b1, 1'b0, 32'h0500, 32'h0510, 1, 3);
        // Empty list: WB in N+1
        run_seq(16'h0000, 32'h0040, 1'b1, 1'b0, 32'h0040, 32'h0040, -1, 0);
        // IB wrap: single register, First and Last together
        run_seq(16'h0001, 32'hFFFFFFFC, 1'b1, 1'b1, 32'h0, 32'h0, -1, 0);
        // DA full list: C4..100, final C0
        run_seq(16'hFFFF, 32'h0100, 1'b0, 1'b0, 32'h00C4, 32'h00C0, -1, 0);

        // Flush after the 5th accepted uop
        ReadyE = 1'b1;
        StartD = 1'b1; RegListD = 16'hFFFF; BaseD = 32'h3000; UpD = 1'b1; PreD = 1'b0;
        tick();
        StartD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("fl_rd",   32'(UopRd), i);
            chk("fl_addr", UopAddr,    32'h3000 + 32'(4 * i));
            tick();
        end
        chk("fl_rd5", 32'(UopRd), 32'd5);
        FlushD = 1'b1;
        tick();
        FlushD = 1'b0;
        chk("fl_valid", 32'(UopValid), 32'd0);
        chk("fl_busy",  32'(BusyD),    32'd0);
        chk("fl_wb",    32'(WBValid),  32'd0);
        chk("fl_rdclr", 32'(UopRd),    32'd0);
        tick();
        chk("fl_wb2",   32'(WBValid),  32'd0);
        chk("fl_valid2", 32'(UopValid), 32'd0);

        // Flush together with start in IDLE: no start
        StartD = 1'b1; FlushD = 1'b1; RegListD = 16'h0003; BaseD = 32'h4000;
        tick();
        StartD = 1'b0; FlushD = 1'b0;
        chk("fs_valid", 32'(UopValid), 32'd0);
        chk("fs_busy",  32'(BusyD),    32'd0);
        tick();
        chk("fs_wb",    32'(WBValid),  32'd0);

        // Async reset mid-RUN
        StartD = 1'b1; RegListD = 16'h00FF; BaseD = 32'h5000;
        tick();
        StartD = 1'b0;
        tick();
        chk("ar_pre_rd",   32'(UopRd), 32'd1);
        chk("ar_pre_addr", UopAddr,    32'h5004);
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", 32'(UopValid), 32'd0);
        chk("ar_busy",  32'(BusyD),    32'd0);
        chk("ar_rd",    32'(UopRd),    32'd0);
        chk("ar_addr",  UopAddr,       32'd0);
        chk("ar_first", 32'(UopFirst), 32'd0);
        chk("ar_wbb",   WBBase,        32'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("ar_idle", 32'(UopValid), 32'd0);

        // Sequencer usable again after reset
        run_seq(16'h0402, 32'h0800, 1'b0, 1'b1, 32'h07F8, 32'h07F8, -1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
